// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem reads, 16-entry BTB
// prediction and the IF/ID register, with a one-entry hold buffer behind a stalled decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned BTB_INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [63:0] redirect_pc_in,
  input  logic        bp_update_in,
  input  logic [63:0] bp_update_pc_in,
  input  logic        bp_update_taken_in,
  input  logic [63:0] bp_update_target_in,
  output logic [63:0] imem_address_out,
  output logic        imem_read_out,
  input  logic        imem_ready_in,
  input  logic [63:0] imem_read_value_in,
  output logic        valid_out,
  output logic [63:0] pc_out,
  output logic [63:0] instr_out,
  output logic        branch_predicted_taken_out
);

  localparam int unsigned DEPTH   = 1 << BTB_INDEX_BITS;
  localparam int unsigned TAG_LSB = BTB_INDEX_BITS + 3;
  localparam int unsigned TAG_W   = 64 - TAG_LSB;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] pending_pc_q, pending_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [63:0] hold_pc_q, hold_pc_d;
  logic [63:0] hold_instr_q, hold_instr_d;
  logic        hold_taken_q, hold_taken_d;
  logic        valid_q, valid_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] instr_q, instr_d;
  logic        taken_q, taken_d;

  logic [DEPTH-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0] btb_tag_q    [DEPTH];
  logic [TAG_W-1:0] btb_tag_d    [DEPTH];
  logic [63:0]      btb_target_q [DEPTH];
  logic [63:0]      btb_target_d [DEPTH];
  logic [1:0]       btb_ctr_q    [DEPTH];
  logic [1:0]       btb_ctr_d    [DEPTH];

  logic [BTB_INDEX_BITS-1:0] lk_idx, up_idx;
  logic        lk_hit, up_hit, pred_taken, accept;
  logic [63:0] next_pc;
  logic        unused_bits;

  assign unused_bits = ^bp_update_pc_in[2:0];

  assign imem_read_out    = (state_q == ST_FETCH && !hold_valid_q) || state_q == ST_DRAIN;
  assign imem_address_out = fetch_pc_q;
  assign accept           = imem_read_out && imem_ready_in;

  assign valid_out                  = valid_q;
  assign pc_out                     = pc_q;
  assign instr_out                  = instr_q;
  assign branch_predicted_taken_out = taken_q;

  assign lk_idx     = fetch_pc_q[BTB_INDEX_BITS+2:3];
  assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == fetch_pc_q[63:TAG_LSB]);
  assign pred_taken = lk_hit && btb_ctr_q[lk_idx][1];
  assign next_pc    = pred_taken ? btb_target_q[lk_idx] : fetch_pc_q + 64'd8;

  assign up_idx = bp_update_pc_in[BTB_INDEX_BITS+2:3];
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == bp_update_pc_in[63:TAG_LSB]);

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_ctr_d    = btb_ctr_q;
    if (bp_update_in) begin
      if (up_hit) begin
        if (bp_update_taken_in) begin
          btb_ctr_d[up_idx]    = (btb_ctr_q[up_idx] == 2'b11) ? 2'b11 : btb_ctr_q[up_idx] + 2'd1;
          btb_target_d[up_idx] = bp_update_target_in;
        end else begin
          btb_ctr_d[up_idx] = (btb_ctr_q[up_idx] == 2'b00) ? 2'b00 : btb_ctr_q[up_idx] - 2'd1;
        end
      end else if (bp_update_taken_in) begin
        btb_valid_d[up_idx]  = 1'b1;
        btb_tag_d[up_idx]    = bp_update_pc_in[63:TAG_LSB];
        btb_target_d[up_idx] = bp_update_target_in;
        btb_ctr_d[up_idx]    = 2'b10;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    hold_taken_d = hold_taken_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    taken_d      = taken_q;

    if (redirect_in) begin
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
      case (state_q)
        ST_FETCH: begin
          // An unanswered request must complete before the new PC can be issued.
          if (imem_read_out && !imem_ready_in) begin
            pending_pc_d = redirect_pc_in;
            state_d      = ST_DRAIN;
          end else begin
            fetch_pc_d = redirect_pc_in;
          end
        end
        ST_DRAIN: begin
          pending_pc_d = redirect_pc_in;
          if (imem_ready_in) begin
            fetch_pc_d = redirect_pc_in;
            state_d    = ST_FETCH;
          end
        end
        default: begin
          fetch_pc_d = redirect_pc_in;
          state_d    = ST_FETCH;
        end
      endcase
    end else begin
      if (!stall_in) begin
        if (hold_valid_q) begin
          valid_d      = 1'b1;
          pc_d         = hold_pc_q;
          instr_d      = hold_instr_q;
          taken_d      = hold_taken_q;
          hold_valid_d = 1'b0;
        end else if (state_q == ST_FETCH && accept) begin
          valid_d = 1'b1;
          pc_d    = fetch_pc_q;
          instr_d = imem_read_value_in;
          taken_d = pred_taken;
        end else begin
          valid_d = 1'b0;
        end
      end

      case (state_q)
        ST_FETCH: begin
          if (accept) begin
            fetch_pc_d = next_pc;
            if (stall_in) begin
              hold_valid_d = 1'b1;
              hold_pc_d    = fetch_pc_q;
              hold_instr_d = imem_read_value_in;
              hold_taken_d = pred_taken;
            end
          end
        end
        ST_DRAIN: begin
          if (imem_ready_in) begin
            fetch_pc_d = pending_pc_q;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      hold_taken_q <= 1'b0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      taken_q      <= 1'b0;
      btb_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_taken_q <= hold_taken_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      taken_q      <= taken_d;
      btb_valid_q  <= btb_valid_d;
    end
  end

  // Entry payload is only meaningful behind its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
    btb_ctr_q    <= btb_ctr_d;
  end

endmodule
